pc_sequencer: RTL and testbench

Sequencing controller for the fetch-stage program counter register. Each cycle it chooses the next fetch address (reset vector, PC+4, branch target or jump target) and drives the PC register's `PCNext`/`PCWrite` inputs. It also handles fetch stalls from the hazard unit and instruction memory, flushes IF after redirects, and halts the fetch stream if a stall never clears. It sits between the hazard/branch-resolution logic and the PC register.

---
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencing FSM; optional alignment check via PCSEQ_ALIGN_CHECK_EN
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR   = 32'h80000180,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          STALL_LIMIT  = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        HazardStall,
    input  logic        IMemReady,
    output logic [31:0] PCNext,
    output logic        PCWrite,
    output logic        IF_Flush,
    output logic        StallTimeout,
    output logic        AlignFault,
    output logic [1:0]  SeqState
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] STALL_MAX  = 8'(STALL_LIMIT);

    state_t      state_q, state_d;
    logic [2:0]  flush_q, flush_d;
    logic [7:0]  stall_q, stall_d;
    logic        timeout_q, timeout_d;
    logic [31:0] raw_target, redirect_pc, pc_next;
    logic        pc_write, if_flush, redirect_fire;

    // Branch wins over jump: it belongs to the older instruction.
    assign raw_target = BranchTaken ? BranchTarget : JumpTarget;

`ifdef PCSEQ_ALIGN_CHECK_EN
    logic align_q;
    logic misaligned;

    assign misaligned  = (raw_target[1:0] != 2'b00);
    assign redirect_pc = misaligned ? EXC_VECTOR : raw_target;
    assign AlignFault  = align_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            align_q <= 1'b0;
        end else if (redirect_fire && misaligned) begin
            align_q <= 1'b1;
        end
    end
`else
    logic unused_exc;

    assign unused_exc  = ^EXC_VECTOR;
    assign redirect_pc = raw_target;
    assign AlignFault  = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        flush_d       = flush_q;
        stall_d       = stall_q;
        timeout_d     = timeout_q;
        pc_next       = PCResult;
        pc_write      = 1'b0;
        if_flush      = 1'b0;
        redirect_fire = 1'b0;
        case (state_q)
            BOOT: begin
                pc_next  = RESET_VECTOR;
                pc_write = 1'b1;
                if_flush = 1'b1;
                state_d  = RUN;
            end
            RUN, FLUSH: begin
                if (state_q == FLUSH) begin
                    if_flush = 1'b1;
                    flush_d  = flush_q - 3'd1;
                    if (flush_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
                if (BranchTaken || Jump) begin
                    redirect_fire = 1'b1;
                    pc_next       = redirect_pc;
                    pc_write      = 1'b1;
                    if_flush      = 1'b1;
                    flush_d       = FLUSH_LOAD;
                    stall_d       = 8'd0;
                    state_d       = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
                end else if (HazardStall || !IMemReady) begin
                    stall_d = stall_q + 8'd1;
                    if (stall_d == STALL_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = HALT;
                    end
                end else begin
                    pc_next  = PCResult + 32'd4;
                    pc_write = 1'b1;
                    stall_d  = 8'd0;
                end
            end
            default: begin
                if_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= BOOT;
            flush_q   <= 3'd0;
            stall_q   <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    // Reset holds the state in BOOT, so only the load enable needs gating.
    assign PCNext       = pc_next;
    assign PCWrite      = pc_write & Reset;
    assign IF_Flush     = if_flush;
    assign StallTimeout = timeout_q;
    assign SeqState     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    localparam int FC = 3;
    localparam int SL = 8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCResult;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        HazardStall;
    logic        IMemReady;
    logic [31:0] PCNext;
    logic        PCWrite;
    logic        IF_Flush;
    logic        StallTimeout;
    logic        AlignFault;
    logic [1:0]  SeqState;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 Clk = ~Clk;

    always_ff @(posedge Clk) begin
        if (PCWrite) PCResult <= PCNext;
    end

    pc_sequencer #(
        .RESET_VECTOR(32'h00000000),
        .EXC_VECTOR  (32'h80000180),
        .FLUSH_CYCLES(FC),
        .STALL_LIMIT (SL)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PCResult    (PCResult),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .HazardStall (HazardStall),
        .IMemReady   (IMemReady),
        .PCNext      (PCNext),
        .PCWrite     (PCWrite),
        .IF_Flush    (IF_Flush),
        .StallTimeout(StallTimeout),
        .AlignFault  (AlignFault),
        .SeqState    (SeqState)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One fetch cycle: drive inputs, check combinational outputs, push the
    // expected PC, then pop and compare it after the edge.
    task automatic step(input string tag, input logic bt, input logic [31:0] btgt,
                        input logic j, input logic [31:0] jtgt, input logic hs, input logic rdy,
                        input logic exp_wr, input logic exp_fl, input logic [31:0] exp_pc,
                        input logic [1:0] exp_st);
        BranchTaken  = bt;
        BranchTarget = btgt;
        Jump         = j;
        JumpTarget   = jtgt;
        HazardStall  = hs;
        IMemReady    = rdy;
        #1;
        chk({tag, "_wr"}, {31'd0, PCWrite}, {31'd0, exp_wr});
        chk({tag, "_flush"}, {31'd0, IF_Flush}, {31'd0, exp_fl});
        exp_q.push_back(exp_pc);
        @(posedge Clk);
        #1;
        chk({tag, "_pc"}, PCResult, exp_q.pop_front());
        chk({tag, "_st"}, {30'd0, SeqState}, {30'd0, exp_st});
    endtask

    task automatic idle(input string tag, input logic exp_fl, input logic [31:0] exp_pc,
                        input logic [1:0] exp_st);
        step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, exp_fl, exp_pc, exp_st);
    endtask

    task automatic stall(input string tag, input logic exp_fl, input logic [31:0] exp_pc,
                         input logic [1:0] exp_st);
        step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, exp_fl, exp_pc, exp_st);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr"}, {31'd0, PCWrite}, 32'd0);
        chk({tag, "_st"}, {30'd0, SeqState}, 32'd0);
        chk({tag, "_flush"}, {31'd0, IF_Flush}, 32'd1);
        chk({tag, "_pcnext"}, PCNext, 32'h00000000);
        chk({tag, "_timeout"}, {31'd0, StallTimeout}, 32'd0);
        chk({tag, "_align"}, {31'd0, AlignFault}, 32'd0);
    endtask

    initial begin
        Reset = 1'b0;
        BranchTaken = 1'b0; BranchTarget = 32'h0;
        Jump = 1'b0; JumpTarget = 32'h0;
        HazardStall = 1'b0; IMemReady = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("por");

        Reset = 1'b1;
        idle("boot", 1'b1, 32'h0, 2'd1);
        for (int i = 1; i <= 8; i++) begin
            idle($sformatf("seq%0d", i), 1'b0, 32'(i * 4), 2'd1);
        end

        step("redir", 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 2'd2);
        idle("fl1", 1'b1, 32'h104, 2'd2);
        idle("fl2", 1'b1, 32'h108, 2'd1);
        idle("post", 1'b0, 32'h10C, 2'd1);

        step("jmp40", 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 2'd2);
        stall("hs_fl1", 1'b1, 32'h40, 2'd2);
        stall("hs_fl2", 1'b1, 32'h40, 2'd1);
        for (int i = 3; i <= 5; i++) begin
            stall($sformatf("hs%0d", i), 1'b0, 32'h40, 2'd1);
        end
        idle("resume", 1'b0, 32'h44, 2'd1);

        for (int i = 1; i < SL; i++) begin
            stall($sformatf("wd%0d", i), 1'b0, 32'h44, 2'd1);
        end
        chk("wd_pre_timeout", {31'd0, StallTimeout}, 32'd0);
        stall("wd_limit", 1'b0, 32'h44, 2'd3);
        chk("wd_timeout", {31'd0, StallTimeout}, 32'd1);
        step("halt_redir", 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 2'd3);

        Reset = 1'b0;
        #1;
        check_reset_outputs("rst_halt");
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        idle("boot2", 1'b1, 32'h0, 2'd1);

        step("jwrap", 1'b0, 32'h0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, 2'd2);
        step("mem0", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 2'd2);
        step("mem1", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000000, 2'd1);
        step("mem2", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 2'd1);
        step("mem3", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000004, 2'd1);
        step("mem4", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000004, 2'd1);
        step("mem5", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000008, 2'd1);

`ifdef PCSEQ_ALIGN_CHECK_EN
        step("jalign", 1'b0, 32'h0, 1'b1, 32'h102, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80000180, 2'd2);
        chk("align_flag", {31'd0, AlignFault}, 32'd1);
        idle("al_fl1", 1'b1, 32'h80000184, 2'd2);
        idle("al_fl2", 1'b1, 32'h80000188, 2'd1);
        chk("align_sticky", {31'd0, AlignFault}, 32'd1);
`else
        step("jalign", 1'b0, 32'h0, 1'b1, 32'h102, 1'b0, 1'b1, 1'b1, 1'b1, 32'h102, 2'd2);
        chk("align_flag", {31'd0, AlignFault}, 32'd0);
        idle("al_fl1", 1'b1, 32'h106, 2'd2);
        idle("al_fl2", 1'b1, 32'h10A, 2'd1);
        chk("align_sticky", {31'd0, AlignFault}, 32'd0);
`endif

        step("br300", 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 2'd2);
        idle("br_fl1", 1'b1, 32'h304, 2'd2);
        Reset = 1'b0;
        #1;
        check_reset_outputs("rst_flush");
        @(posedge Clk);
        #1;
        chk("rst_hold_pc", PCResult, 32'h304);
        Reset = 1'b1;
        idle("boot3", 1'b1, 32'h0, 2'd1);
        idle("after_rst", 1'b0, 32'h4, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
